// File: rtl/reg_file_scan.sv
// Two-read/one-write register file with a valid/ready scan port
// that streams every register out for debug dumps.
module reg_file_scan #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              inicio,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              dbg_start,
    output logic              dbg_busy,
    output logic              dbg_valid,
    input  logic              dbg_ready,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_last
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] e1, e2, es, e0;
    logic              wr_en;

    function automatic logic [DATA_W-1:0] eff(input logic [ADDR_W-1:0] a);
        if (ZERO_REG && a == '0)
            return '0;
        else if (BYPASS && we3 && a3 == a)
            return wd3;
        return regs[a];
    endfunction

    always_comb begin
        nxt_addr = dbg_addr + 1'b1;
        e1       = eff(a1);
        e2       = eff(a2);
        es       = eff(nxt_addr);
        e0       = eff('0);
        wr_en    = we3 && !(ZERO_REG && a3 == '0);
    end

    always_ff @(posedge clk) begin
        if (inicio) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            rd1       <= '0;
            rd2       <= '0;
            state     <= IDLE;
            dbg_valid <= 1'b0;
            dbg_busy  <= 1'b0;
            dbg_last  <= 1'b0;
            dbg_addr  <= '0;
            dbg_data  <= '0;
        end else begin
            if (wr_en)
                regs[a3] <= wd3;
            rd1 <= e1;
            rd2 <= e2;
            unique case (state)
                IDLE: begin
                    if (dbg_start) begin
                        state     <= SCAN;
                        dbg_addr  <= '0;
                        dbg_data  <= e0;
                        dbg_valid <= 1'b1;
                        dbg_busy  <= 1'b1;
                        dbg_last  <= (NREGS == 1);
                    end
                end
                SCAN: begin
                    // Terminal index ends the scan; the address never wraps.
                    if (dbg_ready) begin
                        if (dbg_addr == LAST) begin
                            state     <= IDLE;
                            dbg_valid <= 1'b0;
                            dbg_busy  <= 1'b0;
                            dbg_last  <= 1'b0;
                            dbg_data  <= '0;
                        end else begin
                            dbg_addr <= nxt_addr;
                            dbg_data <= es;
                            dbg_last <= (nxt_addr == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg_file_scan.md
Name: reg_file_scan

Overview:
- Parametrised successor of the pipeline register file: two registered read ports, one write port, optional hardwired zero register, optional write-to-read forwarding.
- Replaces the 32 flat per-register debug outputs with a sequential scan port: a valid/ready streamed dump of every register, one per handshake.
- Sits in the decode stage; the scan port feeds the debug/UART dump logic.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, address width; NREGS = 2**ADDR_W registers (derived, not overridable).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = same-edge write data is forwarded to read and scan loads; 0 = reads return the pre-write value.

Ports:
- clk, in, 1, single clock; all state updates on posedge.
- inicio, in, 1, synchronous active-high reset.
- a1, in, ADDR_W, read port 1 address.
- a2, in, ADDR_W, read port 2 address.
- a3, in, ADDR_W, write address.
- wd3, in, DATA_W, write data.
- we3, in, 1, write enable.
- rd1, out, DATA_W, registered read data for port 1.
- rd2, out, DATA_W, registered read data for port 2.
- dbg_start, in, 1, single-cycle request to begin a scan.
- dbg_busy, out, 1, scan in progress.
- dbg_valid, out, 1, dbg_addr/dbg_data hold a valid entry.
- dbg_ready, in, 1, consumer accepts the current entry.
- dbg_addr, out, ADDR_W, register index of the current entry.
- dbg_data, out, DATA_W, register value of the current entry.
- dbg_last, out, 1, current entry is register NREGS-1.

Behaviour:
- Reset (inicio=1 at an edge) has priority over all other inputs:
  - all registers <= 0;
  - rd1, rd2, dbg_data, dbg_addr <= 0;
  - dbg_valid, dbg_busy, dbg_last <= 0;
  - FSM <= IDLE;
  - any scan in progress is aborted with no further handshakes;
  - we3 in the reset cycle is ignored.
- Write: at the edge, if we3=1 and not (ZERO_REG=1 and a3=0), then reg[a3] <= wd3.
- Read: 1-cycle latency; rd1 at edge t+1 reflects a1 sampled at edge t (same for rd2/a2).
  - effective(a) = 0 if ZERO_REG=1 and a=0;
  - else wd3 if BYPASS=1, we3=1 and a3=a;
  - else reg[a].
- Both read ports may hit the same address, or the write address, in the same cycle.
- Scan FSM, two states:
  - IDLE: dbg_busy=0, dbg_valid=0. If dbg_start=1 at an edge, then dbg_addr <= 0, dbg_data <= effective(0), dbg_valid <= 1, dbg_busy <= 1, dbg_last <= (NREGS==1), and the FSM goes to SCAN.
  - SCAN, dbg_valid=1 and dbg_ready=0: dbg_addr, dbg_data and dbg_last hold stable. Writes to the displayed register do not alter dbg_data.
  - SCAN, dbg_valid=1 and dbg_ready=1:
    - if dbg_addr=NREGS-1, then dbg_valid, dbg_busy, dbg_last <= 0 and the FSM goes to IDLE;
    - else dbg_addr <= dbg_addr+1, dbg_data <= effective(dbg_addr+1), and dbg_last <= (dbg_addr+1 == NREGS-1).
  - Sustained ready gives one entry per cycle. A scan completes in NREGS handshakes, minimum NREGS cycles.
- dbg_start while busy is ignored; it is not queued.
- dbg_start on the same edge as the final handshake is ignored; the next start is accepted from IDLE.
- dbg_addr increments without wrap: the terminal index ends the scan.
- Register writes and reads continue normally during a scan. The scan never stalls the datapath.
- dbg_data is driven to 0 whenever the FSM is in IDLE.

Test Plan:
- Reset/zero:
  - stimulus: inicio=1 for one cycle; then read a1=7, a2=0.
  - response: rd1=0, rd2=0, dbg_valid=0.
  - stimulus: we3=1, a3=0, wd3=0xDEADBEEF; then read a1=0.
  - response: rd1=0 (ZERO_REG=1).
- Write/read latency and bypass:
  - stimulus: we3=1, a3=5, wd3=0x12345678 with a1=5 on the same edge.
  - response: next cycle rd1=0x12345678 with BYPASS=1; rd1=old value (0) with BYPASS=0.
  - response: a following read of a1=5 returns 0x12345678 in both cases.
- Full scan, ready held high:
  - stimulus: preload reg[i]=i*3 for i=1..31; pulse dbg_start.
  - response: 32 consecutive valid cycles, addr 0..31, data 0,3,6..93.
  - response: dbg_last=1 only with addr=31; busy clears the cycle after.
- Backpressure:
  - stimulus: during a scan, dbg_ready=0 for 4 cycles at addr=10 while we3 writes reg[10]=0xAA.
  - response: dbg_addr=10 and dbg_data=30 stable across the 4 cycles.
  - response: once ready returns, the scan resumes at addr=11; a later read of reg[10] returns 0xAA.
- Bypass on scan load:
  - stimulus: we3 writes reg[11]=0x55 on the same edge that accepts addr=10.
  - response: entry addr=11 shows 0x55 with BYPASS=1, or 33 with BYPASS=0.
- Start-while-busy and reset mid-scan:
  - stimulus: dbg_start at addr=3.
  - response: ignored; the scan still ends at addr=31.
  - stimulus: inicio=1 at addr=20.
  - response: next cycle dbg_valid=0, dbg_busy=0, and all registers read 0.
